// File: rtl/dpi_result_collector.sv
// dpi_result_collector
// Collects results from a DPI call whose outputs change on the falling edge.
// {in_done, in_result} is sampled on the rising edge, and each done pulse
// pushes one word into a small first-word-fall-through FIFO.
// The FIFO is drained through a valid/ready port.
// Words that arrive while the FIFO is full are counted as drops.
// Every accepted word is also added into a running sum.
module dpi_result_collector #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_done,
  input  logic [DATA_W-1:0]          in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow,
  output logic [DATA_W-1:0]          accum
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] head_next;

  assign out_valid = (level != '0);

  // Handshake decode: a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    pop  = out_valid & out_ready;
    push = in_done & ((level < DEPTH_L) | pop);
    drop = in_done & ~push;
  end

  // Next head word: registered so out_data keeps its last value once the FIFO empties.
  always_comb begin
    head_next = out_data;
    if (pop) begin
      if (level > ONE_L)
        head_next = mem[rd_ptr + PTR_W'(1)];
      else if (push)
        head_next = in_result;
    end else if ((level == '0) && push) begin
      head_next = in_result;
    end
  end

  // Storage array; content needs no reset because level gates its visibility.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_result;
  end

  // FIFO bookkeeping, drop statistics and the running sum of accepted words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      out_data <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      accum    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      level    <= level + LVL_W'(push) - LVL_W'(pop);
      out_data <= head_next;
      if (push)
        accum <= accum + in_result;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dpi_result_collector.sv
// tb_dpi_result_collector
// Scoreboard bench for dpi_result_collector: accepted words are queued on drive
// and compared against out_data whenever the bench pops the FIFO head.
module tb_dpi_result_collector;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              in_done;
  logic [DATA_W-1:0] in_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        level;
  logic [CNT_W-1:0]  drop_cnt;
  logic              overflow;
  logic [DATA_W-1:0] accum;

  int tests_run;
  int tests_failed;

  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] exp_accum;
  logic [CNT_W-1:0]  exp_drop;
  logic              exp_ovf;

  dpi_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_done   (in_done),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .accum     (accum)
  );

  // Free-running clock; DPI-side inputs are driven on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus plus the reference-model update for that clock.
  task automatic drive_cycle(input logic done, input logic [DATA_W-1:0] res,
                             input logic ready, output logic popped,
                             output logic [DATA_W-1:0] exp_word,
                             output logic [DATA_W-1:0] got_word);
    @(negedge clk);
    in_done   = done;
    in_result = res;
    out_ready = ready;
    popped    = (sb.size() > 0) && ready;
    got_word  = out_data;
    exp_word  = '0;
    if (popped)
      exp_word = sb.pop_front();
    if (done) begin
      if (sb.size() < DEPTH) begin
        sb.push_back(res);
        exp_accum = exp_accum + res;
      end else begin
        exp_ovf = 1'b1;
        if (exp_drop != {CNT_W{1'b1}})
          exp_drop = exp_drop + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_done   = 1'b0;
    out_ready = 1'b0;
  endtask

  // Clear the reference model to match a freshly reset DUT.
  task automatic clear_model();
    sb.delete();
    exp_accum = '0;
    exp_drop  = '0;
    exp_ovf   = 1'b0;
  endtask

  // Synchronous-looking reset pulse used between scenarios.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_done = 1'b0;
    in_result = '0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fifo: valid=%0b level=%0d data=%h want 0/0/0", out_valid, level, out_data);
    end
    tests_run++;
    if (drop_cnt !== '0 || overflow !== 1'b0 || accum !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stats: drop=%0d ovf=%0b accum=%h want 0/0/0", drop_cnt, overflow, accum);
    end
  endtask

  task automatic test_single();
    logic p;
    logic [DATA_W-1:0] e, g;
    drive_cycle(1'b1, 32'h0000_00A5, 1'b0, p, e, g);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5 || level !== 3'd1 || accum !== 32'hA5) begin
      tests_failed++;
      $display("[TB] FAIL single_push: valid=%0b data=%h level=%0d accum=%h want 1/a5/1/a5",
               out_valid, out_data, level, accum);
    end
    drive_cycle(1'b0, '0, 1'b1, p, e, g);
    tests_run++;
    if (!p || g !== e || level !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_pop: got=%h want=%h level=%0d valid=%0b want level 0", g, e, level, out_valid);
    end
  endtask

  task automatic test_fill();
    logic p;
    logic [DATA_W-1:0] e, g;
    do_reset();
    for (int v = 1; v <= 5; v++)
      drive_cycle(1'b1, DATA_W'(v), 1'b0, p, e, g);
    tests_run++;
    if (level !== 3'd4 || drop_cnt !== 16'd1 || overflow !== 1'b1 || accum !== 32'd10) begin
      tests_failed++;
      $display("[TB] FAIL fill_full: level=%0d drop=%0d ovf=%0b accum=%0d want 4/1/1/10",
               level, drop_cnt, overflow, accum);
    end
    for (int v = 1; v <= 4; v++) begin
      drive_cycle(1'b0, '0, 1'b1, p, e, g);
      tests_run++;
      if (!p || g !== e || g !== DATA_W'(v)) begin
        tests_failed++;
        $display("[TB] FAIL fill_drain: got=%h want=%h", g, DATA_W'(v));
      end
    end
    tests_run++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fill_empty: level=%0d valid=%0b want 0/0", level, out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic p;
    logic [DATA_W-1:0] e, g;
    for (int v = 5; v <= 8; v++)
      drive_cycle(1'b1, DATA_W'(v), 1'b0, p, e, g);
    drive_cycle(1'b1, 32'd9, 1'b1, p, e, g);
    tests_run++;
    if (!p || g !== 32'd5 || g !== e) begin
      tests_failed++;
      $display("[TB] FAIL full_pp_pop: got=%h want=%h", g, 32'd5);
    end
    tests_run++;
    if (level !== 3'd4 || drop_cnt !== 16'd1 || out_data !== 32'd6) begin
      tests_failed++;
      $display("[TB] FAIL full_pp_state: level=%0d drop=%0d head=%h want 4/1/6", level, drop_cnt, out_data);
    end
    for (int v = 6; v <= 9; v++) begin
      drive_cycle(1'b0, '0, 1'b1, p, e, g);
      tests_run++;
      if (!p || g !== e || g !== DATA_W'(v)) begin
        tests_failed++;
        $display("[TB] FAIL full_pp_drain: got=%h want=%h", g, DATA_W'(v));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    logic [DATA_W-1:0] e, g;
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), p, e, g);
      if (p) begin
        tests_run++;
        if (g !== e) begin
          tests_failed++;
          $display("[TB] FAIL b2b_order: cycle %0d got=%h want=%h", i, g, e);
        end
      end
      tests_run++;
      if (level !== 3'(sb.size()) || out_valid !== (sb.size() > 0)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_level: cycle %0d level=%0d valid=%0b want %0d", i, level, out_valid, sb.size());
      end
    end
    tests_run++;
    if (accum !== exp_accum || drop_cnt !== exp_drop || overflow !== exp_ovf) begin
      tests_failed++;
      $display("[TB] FAIL b2b_stats: accum=%h drop=%0d ovf=%0b want %h/%0d/%0b",
               accum, drop_cnt, overflow, exp_accum, exp_drop, exp_ovf);
    end
  endtask

  task automatic test_wrap_saturate();
    logic p;
    logic [DATA_W-1:0] e, g;
    do_reset();
    drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, p, e, g);
    drive_cycle(1'b1, 32'h2, 1'b0, p, e, g);
    tests_run++;
    if (accum !== 32'h1) begin
      tests_failed++;
      $display("[TB] FAIL accum_wrap: accum=%h want 00000001", accum);
    end
    repeat (2) drive_cycle(1'b0, '0, 1'b1, p, e, g);
    for (int v = 0; v < 4; v++)
      drive_cycle(1'b1, 32'h100 + DATA_W'(v), 1'b0, p, e, g);
    for (int i = 0; i < (1 << CNT_W) + 3; i++)
      drive_cycle(1'b1, 32'h5000 + DATA_W'(i), 1'b0, p, e, g);
    tests_run++;
    if (drop_cnt !== 16'hFFFF || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_saturate: drop=%h ovf=%0b want ffff/1", drop_cnt, overflow);
    end
    tests_run++;
    if (accum !== 32'h1 + 32'h406 || accum !== exp_accum || out_data !== 32'h100 || level !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL drop_no_accum: accum=%h head=%h level=%0d want %h/100/4",
               accum, out_data, level, 32'h407);
    end
  endtask

  task automatic test_async_reset();
    logic p;
    logic [DATA_W-1:0] e, g;
    do_reset();
    for (int v = 0; v < 4; v++)
      drive_cycle(1'b1, 32'h60 + DATA_W'(v), 1'b0, p, e, g);
    drive_cycle(1'b0, '0, 1'b1, p, e, g);
    tests_run++;
    if (level !== 3'd3 || g !== 32'h60) begin
      tests_failed++;
      $display("[TB] FAIL areset_setup: level=%0d got=%h want 3/60", level, g);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== '0 ||
        drop_cnt !== '0 || overflow !== 1'b0 || accum !== '0) begin
      tests_failed++;
      $display("[TB] FAIL areset_now: valid=%0b level=%0d data=%h drop=%0d ovf=%0b accum=%h want all 0",
               out_valid, level, out_data, drop_cnt, overflow, accum);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    drive_cycle(1'b1, 32'h77, 1'b0, p, e, g);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || level !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL areset_after: valid=%0b data=%h level=%0d want 1/77/1", out_valid, out_data, level);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_back_to_back();
    test_wrap_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
